// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: load/store unit for the MEM pipeline stage.
// One bus access per instruction: IDLE -> BUSY (wait for dmem_ready or time out)
// -> DONE (one unstalled cycle) -> IDLE. Illegal, misaligned or ambiguous
// requests fault in IDLE without touching the bus.
module mem_stage_lsu #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_MEM,
   input  logic        MemRead_MEM,
   input  logic        MemWrite_MEM,
   input  logic [2:0]  funct3_MEM,
   input  logic [31:0] ALU_OUT_MEM,
   input  logic [31:0] rs2_data_MEM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic [31:0] red_data_MEM,
   output logic        stall_MEM,
   output logic        access_fault_MEM
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Counter value seen on the last BUSY cycle allowed before giving up.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  state_reg, state_next;
   logic [7:0]  cnt_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic [3:0]  be_reg;
   logic        we_reg;
   logic [2:0]  f3_reg;
   logic [1:0]  lane_reg;
   logic        fault_reg;
   logic [31:0] red_reg;

   logic        in_idle, in_busy, in_done;
   logic        mem_op, one_op, legal, aligned;
   logic        start, idle_fault, timed_out;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic [31:0] load_ext;
   logic [7:0]  rd_bytes [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign in_idle = (state_reg == IDLE);
   assign in_busy = (state_reg == BUSY);
   assign in_done = (state_reg == DONE);

   // Request decode: legality depends on direction, alignment on access size.
   assign mem_op = MemRead_MEM | MemWrite_MEM;
   assign one_op = MemRead_MEM ^ MemWrite_MEM;

   // Legal size encodings; the unsigned variants exist only for loads.
   always_comb begin
      legal = 1'b0;
      case (funct3_MEM)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = MemRead_MEM & ~MemWrite_MEM;
         default:                legal = 1'b0;
      endcase
   end

   // Halfwords need an even address, words a multiple of four; bytes always fit.
   always_comb begin
      aligned = 1'b1;
      case (funct3_MEM[1:0])
         2'b01:   aligned = ~ALU_OUT_MEM[0];
         2'b10:   aligned = (ALU_OUT_MEM[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
   end

   assign start      = in_idle & valid_MEM & one_op & legal & aligned;
   assign idle_fault = in_idle & valid_MEM & mem_op & ~(one_op & legal & aligned);
   assign timed_out  = in_busy & ~dmem_ready & (cnt_reg == CNT_LAST);

   // Store lane placement: enables shifted to the addressed lane, data replicated.
   always_comb begin
      be_next    = 4'b1111;
      wdata_next = rs2_data_MEM;
      case (funct3_MEM[1:0])
         2'b00: begin
            be_next    = 4'b0001 << ALU_OUT_MEM[1:0];
            wdata_next = {4{rs2_data_MEM[7:0]}};
         end
         2'b01: begin
            be_next    = 4'b0011 << {ALU_OUT_MEM[1], 1'b0};
            wdata_next = {2{rs2_data_MEM[15:0]}};
         end
         default: begin
            be_next    = 4'b1111;
            wdata_next = rs2_data_MEM;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_rd_lane
         assign rd_bytes[gi] = dmem_rdata[8*gi +: 8];
      end
   endgenerate

   assign byte_sel = rd_bytes[lane_reg];
   assign half_sel = lane_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

   // Load extension selected by the latched size/sign code.
   always_comb begin
      load_ext = dmem_rdata;
      case (f3_reg)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_ext = {24'd0, byte_sel};
         3'b101:  load_ext = {16'd0, half_sel};
         default: load_ext = dmem_rdata;
      endcase
   end

   // Next-state logic; ready on the last allowed cycle still completes normally.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = BUSY;
         BUSY:    if (dmem_ready || timed_out) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register; reset drops out of BUSY immediately, releasing dmem_req.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Request latch, wait counter, load result capture and timeout flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg   <= 8'd0;
         addr_reg  <= 32'd0;
         wdata_reg <= 32'd0;
         be_reg    <= 4'd0;
         we_reg    <= 1'b0;
         f3_reg    <= 3'd0;
         lane_reg  <= 2'd0;
         fault_reg <= 1'b0;
         red_reg   <= 32'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  cnt_reg   <= 8'd0;
                  addr_reg  <= {ALU_OUT_MEM[31:2], 2'b00};
                  wdata_reg <= wdata_next;
                  be_reg    <= MemWrite_MEM ? be_next : 4'b0000;
                  we_reg    <= MemWrite_MEM;
                  f3_reg    <= funct3_MEM;
                  lane_reg  <= ALU_OUT_MEM[1:0];
                  fault_reg <= 1'b0;
               end
            end
            BUSY: begin
               cnt_reg <= cnt_reg + 8'd1;
               if (dmem_ready) begin
                  if (!we_reg) red_reg <= load_ext;
               end else if (timed_out) begin
                  red_reg   <= 32'd0;
                  fault_reg <= 1'b1;
               end
            end
            default: begin
               fault_reg <= 1'b0;
            end
         endcase
      end
   end

   assign dmem_req         = in_busy;
   assign dmem_we          = in_busy & we_reg;
   assign dmem_be          = in_busy ? be_reg : 4'b0000;
   assign dmem_addr        = addr_reg;
   assign dmem_wdata       = wdata_reg;
   assign red_data_MEM     = red_reg;
   assign stall_MEM        = start | in_busy;
   assign access_fault_MEM = idle_fault | (in_done & fault_reg);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed table-driven bench for mem_stage_lsu (TIMEOUT=4),
// plus hand-written sequences for idle behaviour, timeout and reset mid-access.
module tb_mem_stage_lsu;

   logic        clk;
   logic        reset;
   logic        valid_MEM;
   logic        MemRead_MEM;
   logic        MemWrite_MEM;
   logic [2:0]  funct3_MEM;
   logic [31:0] ALU_OUT_MEM;
   logic [31:0] rs2_data_MEM;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata;
   logic        dmem_ready;
   logic [31:0] red_data_MEM;
   logic        stall_MEM;
   logic        access_fault_MEM;

   int checks = 0;
   int errors = 0;

   mem_stage_lsu #(.TIMEOUT(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .valid_MEM        (valid_MEM),
      .MemRead_MEM      (MemRead_MEM),
      .MemWrite_MEM     (MemWrite_MEM),
      .funct3_MEM       (funct3_MEM),
      .ALU_OUT_MEM      (ALU_OUT_MEM),
      .rs2_data_MEM     (rs2_data_MEM),
      .dmem_req         (dmem_req),
      .dmem_we          (dmem_we),
      .dmem_addr        (dmem_addr),
      .dmem_wdata       (dmem_wdata),
      .dmem_be          (dmem_be),
      .dmem_rdata       (dmem_rdata),
      .dmem_ready       (dmem_ready),
      .red_data_MEM     (red_data_MEM),
      .stall_MEM        (stall_MEM),
      .access_fault_MEM (access_fault_MEM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] rs2;
      logic [31:0] rdata;
      int          waitc;
      logic        fault;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_be;
      logic [31:0] exp_red;
      int          exp_stalls;
   } vec_t;

   localparam int NVEC = 14;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_req(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rs2);
      valid_MEM    = 1'b1;
      MemRead_MEM  = rd;
      MemWrite_MEM = wr;
      funct3_MEM   = f3;
      ALU_OUT_MEM  = addr;
      rs2_data_MEM = rs2;
      dmem_ready   = 1'b0;
      dmem_rdata   = 32'd0;
   endtask

   task automatic idle_inputs();
      valid_MEM    = 1'b0;
      MemRead_MEM  = 1'b0;
      MemWrite_MEM = 1'b0;
      dmem_ready   = 1'b0;
   endtask

   // Apply one table record and follow it through to DONE (or the fault cycle).
   task automatic run_vec(input int idx, input vec_t v);
      int  stalls;
      int  busy;
      bit  done;
      @(negedge clk);
      drive_req(v.rd, v.wr, v.f3, v.addr, v.rs2);
      #1;
      if (v.fault) begin
         chk("fault_flag", {31'd0, access_fault_MEM}, 32'd1);
         chk("fault_stall", {31'd0, stall_MEM}, 32'd0);
         chk("fault_req", {31'd0, dmem_req}, 32'd0);
         @(negedge clk);
         chk("fault_req_next", {31'd0, dmem_req}, 32'd0);
         chk("fault_red", red_data_MEM, v.exp_red);
      end else begin
         chk("start_stall", {31'd0, stall_MEM}, 32'd1);
         chk("start_fault", {31'd0, access_fault_MEM}, 32'd0);
         stalls = 1;
         busy   = 0;
         done   = 0;
         while (!done) begin
            @(negedge clk);
            if (dmem_req) begin
               busy++;
               stalls += stall_MEM ? 1 : 0;
               chk("busy_stall", {31'd0, stall_MEM}, 32'd1);
               chk("busy_addr", dmem_addr, v.exp_addr);
               if (busy == 1) begin
                  chk("busy_we", {31'd0, dmem_we}, {31'd0, v.wr});
                  chk("busy_be", {28'd0, dmem_be}, {28'd0, v.exp_be});
                  if (v.wr) chk("busy_wdata", dmem_wdata, v.exp_wdata);
               end
               dmem_ready = (busy == v.waitc + 1);
               dmem_rdata = dmem_ready ? v.rdata : 32'hDEAD_BEEF;
               if (busy > 40) begin
                  chk("busy_bound", busy, v.waitc + 1);
                  done = 1;
               end
            end else begin
               chk("done_stall", {31'd0, stall_MEM}, 32'd0);
               chk("done_fault", {31'd0, access_fault_MEM}, 32'd0);
               chk("done_we_be", {27'd0, dmem_we, dmem_be}, 32'd0);
               chk("done_red", red_data_MEM, v.exp_red);
               chk("stall_cycles", stalls, v.exp_stalls);
               done = 1;
            end
         end
      end
      idle_inputs();
      $display("vec %0d: rd=%0b wr=%0b f3=%03b addr=0x%08h red=0x%08h", idx, v.rd, v.wr,
               v.f3, v.addr, red_data_MEM);
   endtask

   initial begin
      int reqs;
      vec_t v;

      //          rd    wr    f3      addr          rs2           rdata         wait flt  exp_addr      exp_wdata     be       exp_red       stalls
      vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h8011_2233, 0, 1'b0, 32'h0000_0100, 32'h0,        4'b0000, 32'hFFFF_FF80, 2};
      vecs[1]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        1, 1'b0, 32'h0000_0200, 32'hABCD_ABCD, 4'b1100, 32'hFFFF_FF80, 3};
      vecs[2]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'hFFFF_FF80, 0};
      vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0,        32'hF00D_0000, 3, 1'b0, 32'h0000_0000, 32'h0,        4'b0000, 32'h0000_F00D, 5};
      vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0006, 32'h0,        32'h8001_1234, 0, 1'b0, 32'h0000_0004, 32'h0,        4'b0000, 32'hFFFF_8001, 2};
      vecs[5]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'h0,        32'h0000_AB00, 2, 1'b0, 32'h0000_0000, 32'h0,        4'b0000, 32'h0000_00AB, 4};
      vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h0000_000A, 32'h0000_00EE, 32'h0,        0, 1'b0, 32'h0000_0008, 32'hEEEE_EEEE, 4'b0100, 32'h0000_00AB, 2};
      vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        3, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0000_00AB, 5};
      vecs[8]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0003, 32'h0,        32'h0,        0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0000_00AB, 0};
      vecs[9]  = '{1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0000_00AB, 0};
      vecs[10] = '{1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0000_00AB, 0};
      vecs[11] = '{1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0,        32'h1234_5678, 1, 1'b0, 32'h0000_0020, 32'h0,        4'b0000, 32'h1234_5678, 3};
      vecs[12] = '{1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h1234_5678, 0};
      vecs[13] = '{1'b1, 1'b0, 3'b000, 32'h0000_0000, 32'h0,        32'h0000_007F, 0, 1'b0, 32'h0000_0000, 32'h0,        4'b0000, 32'h0000_007F, 2};

      // Reset state with quiet inputs.
      reset        = 1'b1;
      funct3_MEM   = 3'd0;
      ALU_OUT_MEM  = 32'd0;
      rs2_data_MEM = 32'd0;
      dmem_rdata   = 32'd0;
      idle_inputs();
      repeat (2) @(negedge clk);
      chk("rst_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_we_be", {27'd0, dmem_we, dmem_be}, 32'd0);
      chk("rst_addr", dmem_addr, 32'd0);
      chk("rst_wdata", dmem_wdata, 32'd0);
      chk("rst_red", red_data_MEM, 32'd0);
      chk("rst_stall_fault", {30'd0, stall_MEM, access_fault_MEM}, 32'd0);
      reset = 1'b0;
      $display("reset: state checked");

      for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

      // valid_MEM low with a misaligned load and a stray ready: nothing happens.
      @(negedge clk);
      drive_req(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0);
      valid_MEM  = 1'b0;
      dmem_ready = 1'b1;
      dmem_rdata = 32'h5555_5555;
      #1;
      chk("novalid_fault", {31'd0, access_fault_MEM}, 32'd0);
      chk("novalid_stall", {31'd0, stall_MEM}, 32'd0);
      @(negedge clk);
      chk("novalid_req", {31'd0, dmem_req}, 32'd0);
      chk("stray_ready_red", red_data_MEM, 32'h0000_007F);
      idle_inputs();
      $display("novalid: red=0x%08h", red_data_MEM);

      // Timeout: ready never arrives, request held for exactly TIMEOUT cycles.
      @(negedge clk);
      drive_req(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0);
      #1;
      chk("to_start_stall", {31'd0, stall_MEM}, 32'd1);
      reqs = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!dmem_req) break;
         reqs++;
      end
      chk("to_req_cycles", reqs, 32'd4);
      chk("to_fault", {31'd0, access_fault_MEM}, 32'd1);
      chk("to_stall", {31'd0, stall_MEM}, 32'd0);
      chk("to_red", red_data_MEM, 32'd0);
      idle_inputs();
      @(negedge clk);
      chk("to_fault_once", {31'd0, access_fault_MEM}, 32'd0);
      $display("timeout: req cycles=%0d red=0x%08h", reqs, red_data_MEM);

      // Load something nonzero, then reset in the middle of the next access.
      v = '{1'b1, 1'b0, 3'b010, 32'h0000_0030, 32'h0, 32'h0BAD_F00D, 0, 1'b0,
            32'h0000_0030, 32'h0, 4'b0000, 32'h0BAD_F00D, 2};
      run_vec(100, v);
      @(negedge clk);
      drive_req(1'b1, 1'b0, 3'b010, 32'h0000_0050, 32'h0);
      @(negedge clk);
      chk("mid_busy_req", {31'd0, dmem_req}, 32'd1);
      #2;
      reset = 1'b1;
      idle_inputs();
      #1;
      chk("async_req_drop", {31'd0, dmem_req}, 32'd0);
      chk("async_stall", {31'd0, stall_MEM}, 32'd0);
      chk("async_red", red_data_MEM, 32'd0);
      chk("async_addr", dmem_addr, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      $display("reset mid-busy: req=%0b", dmem_req);

      v = '{1'b1, 1'b0, 3'b010, 32'h0000_0060, 32'h0, 32'hCAFE_F00D, 0, 1'b0,
            32'h0000_0060, 32'h0, 4'b0000, 32'hCAFE_F00D, 2};
      run_vec(101, v);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute guard against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 Parameter TIMEOUT, default 255, sets the maximum number of BUSY cycles spent waiting for dmem_ready before a fault; range 1..255.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high; takes effect immediately, independent of clk.
REQ-004 valid_MEM  in  1  the MEM stage holds a real instruction.
REQ-005 MemRead_MEM, MemWrite_MEM  in  1 each  load / store request.
REQ-006 funct3_MEM  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 ALU_OUT_MEM  in  32  effective byte address.
REQ-008 rs2_data_MEM  in  32  store data.
REQ-009 dmem_req, dmem_we  out  1 each  bus request / write strobe.
REQ-010 dmem_addr  out  32  word-aligned address, with {ALU_OUT_MEM[31:2],2'b00}.
REQ-011 dmem_wdata  out  32  lane-replicated store data.
REQ-012 dmem_be  out  4  byte enables.
REQ-013 dmem_rdata  in  32  read data, valid when dmem_ready=1.
REQ-014 dmem_ready  in  1  bus completes the access this cycle.
REQ-015 red_data_MEM  out  32  registered, extended load result, fed to the MEM/WB register.
REQ-016 stall_MEM  out  1  holds IF/ID/EX/MEM and drives the MEM/WB write enable low.
REQ-017 access_fault_MEM  out  1  one-cycle fault indication.

Function
REQ-018 FSM states are IDLE, BUSY and DONE.
REQ-019 Start condition in IDLE is valid_MEM & (MemRead_MEM ^ MemWrite_MEM) & legal & aligned.
REQ-020 A legal funct3 is 000, 001 or 010 for stores, and 000, 001, 010, 100 or 101 for loads.
REQ-021 An access is aligned when H has addr[0]=0, W has addr[1:0]=00, and B is always aligned.
REQ-022 IDLE, start condition true: stall_MEM=1 combinationally; latch addr, wdata, be, we and funct3; go to BUSY.
REQ-023 IDLE, fault condition (valid_MEM, with both MemRead and MemWrite set, an illegal funct3, or a misaligned address): access_fault_MEM=1 combinationally; stall_MEM=0; no bus request; stay in IDLE.
REQ-024 BUSY: dmem_req=1; all dmem_* outputs are stable from latched values; stall_MEM=1; the wait counter increments every cycle.
REQ-025 BUSY with dmem_ready=1: for a load, capture the extended result into red_data_MEM; go to DONE.
REQ-026 BUSY, counter reaches TIMEOUT with dmem_ready=0: drop dmem_req next cycle; red_data_MEM=0; go to DONE with the fault flag set.
REQ-027 DONE: stall_MEM=0 for exactly one cycle; access_fault_MEM=1 only if timed out; go to IDLE.
REQ-028 Because stall_MEM is low in DONE, the pipeline advances past the completed instruction, so it is never re-issued.
REQ-029 Latency: an access completed on the first BUSY cycle stalls 2 cycles; each extra wait cycle adds 1.
REQ-030 Byte enables: SB gives 0001<<addr[1:0]; SH gives 0011<<{addr[1],1'b0}; SW gives 1111.
REQ-031 Store write data: SB gives {4{rs2[7:0]}}; SH gives {2{rs2[15:0]}}; SW gives rs2.
REQ-032 Load lane selection: the byte lane is addr[1:0] and the half lane is addr[1].
REQ-033 Load extension: B and H sign-extend; BU and HU zero-extend; W passes through.
REQ-034 red_data_MEM is unchanged by stores, faults (other than timeout) and idle cycles.
REQ-035 dmem_ready outside BUSY is ignored.
REQ-036 valid_MEM=0 never starts an access and never faults.
REQ-037 dmem_we=0 and dmem_be=0000 whenever dmem_req=0.

Reset
REQ-038 While reset=1: state is IDLE, dmem_req=0, dmem_we=0, dmem_be=0000, dmem_addr=0, dmem_wdata=0, red_data_MEM=0, stall_MEM=0 (combinational, as in IDLE), access_fault_MEM=0 (combinational, as in IDLE), and the counter is 0.
REQ-039 Reset asserted in BUSY abandons the access, and dmem_req falls asynchronously without waiting for a clock edge.

Verification
REQ-040 LB at 0x103, dmem_rdata=0x80112233, ready on the first BUSY cycle -> dmem_addr=0x100, be=0000 (read), stall high 2 cycles, red_data_MEM=0xFFFFFF80 in DONE.
REQ-041 SH at 0x202, rs2=0x1234ABCD -> dmem_we=1, be=1100, wdata=0xABCDABCD, addr=0x200; red_data_MEM unchanged.
REQ-042 LW at 0x101 -> access_fault_MEM=1 the same cycle, dmem_req never rises, stall_MEM=0.
REQ-043 LHU at 0x002 with ready after 3 wait cycles and rdata=0xF00D0000 -> stall high 5 cycles, red_data_MEM=0x0000F00D.
REQ-044 TIMEOUT=4, ready held low -> dmem_req high 4 cycles, then DONE with access_fault_MEM=1 and red_data_MEM=0.
REQ-045 Reset pulsed mid-BUSY -> dmem_req=0 before the next edge; after release, the next valid LW completes normally.
